// File: rtl/event_source_arbiter.sv
// rtl/event_source_arbiter.sv - round-robin event source arbiter with burst limit and range filter
module event_source_arbiter #(
    parameter  int NUM_SRC    = 4,
    parameter  int SENSOR_RES = 320,
    parameter  int BURST_MAX  = 4,
    parameter  int CNT_W      = 16,
    localparam int IDX_W      = $clog2(NUM_SRC),
    localparam int BC_W       = $clog2(BURST_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [NUM_SRC*9-1:0] src_x,
    input  logic [NUM_SRC*9-1:0] src_y,
    input  logic [NUM_SRC-1:0]   src_polarity,
    input  logic [NUM_SRC-1:0]   src_enable,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic                 out_valid,
    output logic [8:0]           out_x,
    output logic [8:0]           out_y,
    output logic                 out_polarity,
    output logic [IDX_W-1:0]     out_src,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     drop_count
);

    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [9:0] RES = 10'(SENSOR_RES);

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_owner, w_owner_nxt;
    logic [BC_W-1:0]  r_burst_cnt, w_burst_nxt;
    logic             r_out_valid;
    logic [8:0]       r_out_x, r_out_y;
    logic             r_out_pol;
    logic [IDX_W-1:0] r_out_src;
    logic [CNT_W-1:0] r_drop;

    logic [NUM_SRC-1:0] w_req;
    logic               w_load_ok, w_keep, w_rot_found, w_grant, w_in_range;
    logic [IDX_W-1:0]   w_rot_idx, w_gidx;
    logic [8:0]         w_gx, w_gy;
    logic               w_gpol;

    assign w_req     = src_valid & src_enable;
    assign w_load_ok = !r_out_valid || out_ready;
    assign w_keep    = (r_state == BURST) && w_req[r_owner] && (r_burst_cnt < BC_W'(BURST_MAX));

    // Walk the candidates from farthest to nearest so the first requester after owner wins; owner comes last.
    always_comb begin
        w_rot_found = 1'b0;
        w_rot_idx   = r_owner;
        for (int k = NUM_SRC; k >= 1; k--) begin
            int c;
            c = (int'(r_owner) + k) % NUM_SRC;
            if (w_req[c]) begin
                w_rot_found = 1'b1;
                w_rot_idx   = IDX_W'(c);
            end
        end
    end

    assign w_grant = w_load_ok && (w_keep || w_rot_found);
    assign w_gidx  = w_keep ? r_owner : w_rot_idx;

    always_comb begin
        w_gx   = '0;
        w_gy   = '0;
        w_gpol = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_gidx == IDX_W'(i)) begin
                w_gx   = src_x[i*9 +: 9];
                w_gy   = src_y[i*9 +: 9];
                w_gpol = src_polarity[i];
            end
        end
    end

    assign w_in_range = ({1'b0, w_gx} < RES) && ({1'b0, w_gy} < RES);
    assign src_ready  = w_grant ? (NUM_SRC'(1) << w_gidx) : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_burst_nxt = r_burst_cnt;
        if (w_load_ok) begin
            if (w_keep) begin
                w_burst_nxt = r_burst_cnt + BC_W'(1);
            end else if (w_rot_found) begin
                w_state_nxt = BURST;
                w_owner_nxt = w_rot_idx;
                w_burst_nxt = BC_W'(1);
            end else begin
                w_state_nxt = IDLE;
                w_burst_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= IDX_W'(NUM_SRC - 1);
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_pol   <= 1'b0;
            r_out_src   <= '0;
            r_drop      <= '0;
        end else begin
            if (w_load_ok) begin
                r_out_valid <= w_grant && w_in_range;
            end
            if (w_grant && w_in_range) begin
                r_out_x   <= w_gx;
                r_out_y   <= w_gy;
                r_out_pol <= w_gpol;
                r_out_src <= w_gidx;
            end
            if (w_grant && !w_in_range && (r_drop != '1)) begin
                r_drop <= r_drop + CNT_W'(1);
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_x        = r_out_x;
    assign out_y        = r_out_y;
    assign out_polarity = r_out_pol;
    assign out_src      = r_out_src;
    assign drop_count   = r_drop;

endmodule

// File: tb/tb_event_source_arbiter.sv
// tb/tb_event_source_arbiter.sv - scoreboard bench for event_source_arbiter
module tb_event_source_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  src_valid;
    logic [35:0] src_x;
    logic [35:0] src_y;
    logic [3:0]  src_polarity;
    logic [3:0]  src_enable;
    logic [3:0]  src_ready;
    logic        out_valid;
    logic [8:0]  out_x;
    logic [8:0]  out_y;
    logic        out_polarity;
    logic [1:0]  out_src;
    logic        out_ready;
    logic [3:0]  drop_count;

    // Narrow drop counter so saturation is reachable in a short run.
    event_source_arbiter #(
        .NUM_SRC(4), .SENSOR_RES(320), .BURST_MAX(4), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_x(src_x), .src_y(src_y),
        .src_polarity(src_polarity), .src_enable(src_enable),
        .src_ready(src_ready),
        .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
        .out_polarity(out_polarity), .out_src(out_src),
        .out_ready(out_ready), .drop_count(drop_count)
    );

    typedef struct {
        logic [8:0] x;
        logic [8:0] y;
        logic       pol;
        logic [1:0] src;
    } ev_t;

    ev_t exp_q[$];
    int  gnt_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input int x, input int y, input logic pol);
        src_x[i*9 +: 9]  = 9'(x);
        src_y[i*9 +: 9]  = 9'(y);
        src_polarity[i]  = pol;
    endtask

    task automatic push_ev(input int i);
        ev_t e;
        e.x   = src_x[i*9 +: 9];
        e.y   = src_y[i*9 +: 9];
        e.pol = src_polarity[i];
        e.src = 2'(i);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        src_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Grant monitor: every asserted src_ready must match the next expected grant.
    always @(negedge clk) begin
        if (!rst && src_ready != 4'b0) begin
            n_cmp++;
            if (gnt_q.size() == 0) begin
                n_err++;
                $display("FAIL grant_unexpected: got %b expected none", src_ready);
            end else begin
                int g;
                logic [3:0] e;
                g = gnt_q.pop_front();
                e = 4'b0001 << g;
                if (src_ready !== e) begin
                    n_err++;
                    $display("FAIL grant: got %b expected %b", src_ready, e);
                end
            end
        end
    end

    // Output monitor: every transferred event must match the next expected event.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_unexpected: got x=%0d y=%0d src=%0d expected none", out_x, out_y, out_src);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if ({out_x, out_y, out_polarity, out_src} !== {e.x, e.y, e.pol, e.src}) begin
                    n_err++;
                    $display("FAIL out_event: got x=%0d y=%0d p=%0d s=%0d expected x=%0d y=%0d p=%0d s=%0d",
                             out_x, out_y, out_polarity, out_src, e.x, e.y, e.pol, e.src);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        src_valid = '0;
        src_x = '0;
        src_y = '0;
        src_polarity = '0;
        src_enable = 4'hF;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_xy", {14'b0, out_x, out_y}, 0);
        chk("reset_out_src", 32'(out_src), 0);
        chk("reset_drop", 32'(drop_count), 0);

        // Single event, latency 1
        set_src(0, 40, 300, 1'b1);
        src_valid = 4'b0001;
        gnt_q.push_back(0);
        push_ev(0);
        tick();
        src_valid = '0;
        chk("t1_out_valid", 32'(out_valid), 1);
        chk("t1_out_x", 32'(out_x), 40);
        chk("t1_out_y", 32'(out_y), 300);
        tick();

        // Burst rotation across all four sources
        do_reset();
        for (int i = 0; i < 4; i++) set_src(i, 10 + i, 20 + i, 1'(i));
        src_valid = 4'hF;
        for (int k = 0; k < 20; k++) begin
            gnt_q.push_back((k / 4) % 4);
            push_ev((k / 4) % 4);
        end
        repeat (20) tick();
        src_valid = '0;
        tick();

        // Out-of-range drops, boundary, saturation
        do_reset();
        set_src(1, 320, 5, 1'b0);
        src_valid = 4'b0010;
        gnt_q.push_back(1);
        tick();
        src_valid = '0;
        chk("drop_x_valid", 32'(out_valid), 0);
        chk("drop_x_count", 32'(drop_count), 1);
        set_src(2, 0, 320, 1'b1);
        src_valid = 4'b0100;
        gnt_q.push_back(2);
        tick();
        src_valid = '0;
        chk("drop_y_count", 32'(drop_count), 2);
        set_src(3, 319, 319, 1'b1);
        src_valid = 4'b1000;
        gnt_q.push_back(3);
        push_ev(3);
        tick();
        chk("edge_in_range_valid", 32'(out_valid), 1);
        src_valid = 4'b0010;
        gnt_q.push_back(1);
        tick();
        chk("drop_empties_slot", 32'(out_valid), 0);
        chk("drop_count_3", 32'(drop_count), 3);
        for (int k = 0; k < 20; k++) gnt_q.push_back(1);
        repeat (20) tick();
        src_valid = '0;
        chk("drop_saturate", 32'(drop_count), 15);
        tick();

        // Backpressure stall
        do_reset();
        out_ready = 1'b0;
        set_src(0, 100, 101, 1'b1);
        src_valid = 4'b0001;
        gnt_q.push_back(0);
        push_ev(0);
        tick();
        set_src(0, 102, 103, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_x", 32'(out_x), 100);
            chk("stall_ready_zero", 32'(src_ready), 0);
            tick();
        end
        gnt_q.push_back(0);
        push_ev(0);
        out_ready = 1'b1;
        tick();
        src_valid = '0;
        chk("stall_next_x", 32'(out_x), 102);
        tick();

        // Enable dropped mid-burst
        do_reset();
        for (int i = 0; i < 4; i++) set_src(i, 50 + i, 60 + i, 1'b0);
        src_valid = 4'b1100;
        gnt_q.push_back(2);
        gnt_q.push_back(2);
        push_ev(2);
        push_ev(2);
        repeat (2) tick();
        src_enable = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            gnt_q.push_back(3);
            push_ev(3);
        end
        repeat (6) tick();
        src_valid = '0;
        src_enable = 4'hF;
        tick();

        // Asynchronous reset between edges with a pending output
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) set_src(i, 200 + i, 210 + i, 1'b1);
        src_valid = 4'hF;
        gnt_q.push_back(0);
        tick();
        chk("pre_rst_valid", 32'(out_valid), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_x", 32'(out_x), 0);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        gnt_q.push_back(0);
        push_ev(0);
        tick();
        src_valid = '0;
        chk("post_rst_src", 32'(out_src), 0);
        tick();
        tick();

        chk("grant_queue_empty", 32'(gnt_q.size()), 0);
        chk("event_queue_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
